main_control_fsm: RTL and testbench
===================================

// Module: main_control_fsm
// PURPOSE
//  Multi-cycle MIPS main controller: Moore FSM sequencing FETCH/DECODE/EXECUTE/MEM/WB.
//  Decodes instr[31:26] and drives every datapath enable/mux select.
//  Produces alu_op, which feeds the ALU control decoder (with funct) to form the 4-bit ALU control.
//  Sits between the instruction register and the datapath; one instance per core.
// PARAMETERS
//  MEM_LAT   0   extra wait cycles for each memory access (FETCH, MEMRD, MEMWR); range 0..15
// PORTS
//  clk        in   1  system clock, all state updates on rising edge
//  reset      in   1  synchronous active-high reset
//  op         in   6  opcode instr[31:26] from instruction register
//  zero       in   1  ALU zero flag, sampled in BEQEX
//  iord       out  1  memory address mux: 0=PC, 1=ALUOut
//  mem_write  out  1  data memory write strobe
//  ir_write   out  1  instruction register load
//  reg_dst    out  1  write register: 0=rt, 1=rd
//  mem_to_reg out  1  writeback data: 0=ALUOut, 1=MDR
//  reg_write  out  1  register file write enable
//  alu_src_a  out  1  0=PC, 1=A
//  alu_src_b  out  2  00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
//  alu_op     out  2  00=add, 01=sub, 10=use funct (11 unused, never driven)
//  pc_src     out  2  00=ALUResult, 01=ALUOut, 10=jump target
//  pc_en      out  1  PC load = pc_write | (branch & zero)
//  illegal_op out  1  one-cycle pulse: unsupported opcode seen in DECODE
// BEHAVIOUR
//  - Reset: state=FETCH, wait counter=0. Outputs take FETCH values the next cycle.
//    With MEM_LAT=0: ir_write=1, pc_en=1, alu_src_b=01, all other outputs 0.
//  - Outputs are pure functions of state (and zero, for pc_en); no output registers.
//  - All unlisted outputs are 0 in every state.
//  - FETCH:   iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
//             ir_write/pc_write=1 only in the last wait cycle. -> DECODE.
//  - DECODE:  alu_src_a=0, alu_src_b=11, alu_op=00. Next state by op:
//             lw(100011)/sw(101011) -> MEMADR; R(000000) -> RTYPEEX;
//             beq(000100) -> BEQEX; j(000010) -> JEX;
//             other -> FETCH with illegal_op=1 that cycle.
//  - MEMADR:  alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEMRD; sw -> MEMWR.
//  - MEMRD:   iord=1, held MEM_LAT+1 cycles. -> MEMWB.
//  - MEMWB:   reg_dst=0, mem_to_reg=1, reg_write=1. -> FETCH.
//  - MEMWR:   iord=1; mem_write=1 only in the last wait cycle. -> FETCH.
//  - RTYPEEX: alu_src_a=1, alu_src_b=00, alu_op=10. -> RTYPEWB.
//  - RTYPEWB: reg_dst=1, mem_to_reg=0, reg_write=1. -> FETCH.
//  - BEQEX:   alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1. -> FETCH.
//  - JEX:     pc_src=10, pc_write=1. -> FETCH.
//  - Wait counter (4 bit):
//    - Clears on entry to FETCH/MEMRD/MEMWR; increments each cycle in those states.
//    - The state advances when count==MEM_LAT.
//  - Latency (MEM_LAT=0): lw 5, sw 4, R 4, beq 3, j 3 cycles.
//    Each memory state adds MEM_LAT cycles.
//  - Reset mid-instruction: abandons the instruction; no write strobe in the reset cycle's successor.
//  - Illegal/unreachable state encodings recover to FETCH.
// CONFIGURATION
//  CTRL_ADDI_EN defined:
//    - op 001000 in DECODE -> ADDIEX (alu_src_a=1, alu_src_b=10, alu_op=00)
//      -> ADDIWB (reg_dst=0, mem_to_reg=0, reg_write=1) -> FETCH; 4 cycles.
//  Undefined: op 001000 is illegal (illegal_op pulse, -> FETCH).
// STRUCTURE
//  Package mips_ctrl_pkg:
//    - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
//    - alu_op encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10)
//    - state_t enum
//  Sub-module ctrl_outdec: combinational state_t -> control-word decode.
//  Next-state logic and the wait counter stay in main_control_fsm.
// TESTING
//  1. reset=1 for 2 cycles, op=100011, MEM_LAT=0 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB;
//     reg_write=1 and mem_to_reg=1 on cycle 5 only.
//  2. op=000000 -> alu_op=10 in RTYPEEX; reg_dst=1, reg_write=1 in RTYPEWB; back in FETCH at cycle 5.
//  3. op=000100, zero=1 -> pc_en=1, pc_src=01, alu_op=01 in BEQEX; with zero=0, pc_en=0.
//  4. MEM_LAT=2, op=101011 -> FETCH lasts 3 cycles (ir_write on 3rd only);
//     MEMWR lasts 3 cycles, mem_write on 3rd only.
//  5. op=111111 -> illegal_op=1 for exactly one cycle, then FETCH; op=001000 with and without CTRL_ADDI_EN.
//  6. Assert reset during MEMWR -> mem_write=0 next cycle, state=FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, ALU/mux encodings and state type for the multi-cycle MIPS main controller.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_JEX     = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
  } state_t;

endpackage

// File: rtl/ctrl_outdec.sv
// Combinational control-word decode: state (plus wait-count terminal flag, zero, bad opcode) to datapath controls.
module ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       last,
  input  logic       zero,
  input  logic       op_bad,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       illegal_op
);

  logic pc_write;
  logic branch;

  always_comb begin
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALUOP_ADD;
    pc_src     = PCSRC_ALU;
    pc_write   = 1'b0;
    branch     = 1'b0;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b = SRCB_FOUR;
        ir_write  = last;
        pc_write  = last;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMMSH;
        illegal_op = op_bad;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = last;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
      end
      S_JEX: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: reg_write = 1'b1;
      default: ;
    endcase
  end

  assign pc_en = pc_write | (branch & zero);

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS main controller: Moore FSM with a shared memory wait counter.
// Optional macro CTRL_ADDI_EN adds the ADDIEX/ADDIWB path for opcode 001000.
module main_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       illegal_op
);

  // state     | meaning
  // FETCH     | read instruction at PC, PC+4 (waits MEM_LAT cycles)
  // DECODE    | read registers, precompute branch target, dispatch on op
  // MEMADR    | ALUOut = A + SignImm
  // MEMRD     | read data memory (waits MEM_LAT cycles)
  // MEMWB     | write MDR to rt
  // MEMWR     | write B to data memory (waits MEM_LAT cycles)
  // RTYPEEX   | ALU op from funct
  // RTYPEWB   | write ALUOut to rd
  // BEQEX     | compare A-B, branch on zero
  // JEX       | load jump target
  // ADDIEX    | A + SignImm (CTRL_ADDI_EN only)
  // ADDIWB    | write ALUOut to rt (CTRL_ADDI_EN only)

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t     state;
  state_t     state_n;
  logic [3:0] cnt;
  logic       last;
  logic       op_bad;

  assign last = (cnt == LAT);

  always_comb begin
    state_n = state;
    op_bad  = 1'b0;
    case (state)
      S_FETCH:  if (last) state_n = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_RTYPE:     state_n = S_RTYPEEX;
          OP_BEQ:       state_n = S_BEQEX;
          OP_J:         state_n = S_JEX;
`ifdef CTRL_ADDI_EN
          OP_ADDI:      state_n = S_ADDIEX;
`else
          OP_ADDI: begin
            op_bad  = 1'b1;
            state_n = S_FETCH;
          end
`endif
          default: begin
            op_bad  = 1'b1;
            state_n = S_FETCH;
          end
        endcase
      end
      S_MEMADR:  state_n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (last) state_n = S_MEMWB;
      S_MEMWB:   state_n = S_FETCH;
      S_MEMWR:   if (last) state_n = S_FETCH;
      S_RTYPEEX: state_n = S_RTYPEWB;
      S_RTYPEWB: state_n = S_FETCH;
      S_BEQEX:   state_n = S_FETCH;
      S_JEX:     state_n = S_FETCH;
      S_ADDIEX:  state_n = S_ADDIWB;
      S_ADDIWB:  state_n = S_FETCH;
      default:   state_n = S_FETCH;
    endcase
  end

  // Only the wait states ever hold, so any state change is an entry that restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state) ? 4'd0 : cnt + 4'd1;
    end
  end

  ctrl_outdec u_outdec (
    .state      (state),
    .last       (last),
    .zero       (zero),
    .op_bad     (op_bad),
    .iord       (iord),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .pc_en      (pc_en),
    .illegal_op (illegal_op)
  );

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: expected control words per cycle, MEM_LAT=0 and MEM_LAT=2 instances.
module tb_main_control_fsm;

  // word = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op}
  localparam logic [14:0] W_FETCH_L = 15'b0_0_1_0_0_0_0_01_00_00_1_0;
  localparam logic [14:0] W_FETCH_W = 15'b0_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [14:0] W_DECODE  = 15'b0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [14:0] W_DEC_ILL = 15'b0_0_0_0_0_0_0_11_00_00_0_1;
  localparam logic [14:0] W_MEMADR  = 15'b0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [14:0] W_MEMRD   = 15'b1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [14:0] W_MEMWB   = 15'b0_0_0_0_1_1_0_00_00_00_0_0;
  localparam logic [14:0] W_MEMWR_W = 15'b1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [14:0] W_MEMWR_L = 15'b1_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [14:0] W_RTYPEEX = 15'b0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [14:0] W_RTYPEWB = 15'b0_0_0_1_0_1_0_00_00_00_0_0;
  localparam logic [14:0] W_BEQ_Z1  = 15'b0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [14:0] W_BEQ_Z0  = 15'b0_0_0_0_0_0_1_00_01_01_0_0;
  localparam logic [14:0] W_JEX     = 15'b0_0_0_0_0_0_0_00_00_10_1_0;
  localparam logic [14:0] W_ADDIEX  = 15'b0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [14:0] W_ADDIWB  = 15'b0_0_0_0_0_1_0_00_00_00_0_0;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;

  logic       iord_0, mem_write_0, ir_write_0, reg_dst_0, mem_to_reg_0, reg_write_0, alu_src_a_0;
  logic [1:0] alu_src_b_0, alu_op_0, pc_src_0;
  logic       pc_en_0, illegal_op_0;
  logic       iord_2, mem_write_2, ir_write_2, reg_dst_2, mem_to_reg_2, reg_write_2, alu_src_a_2;
  logic [1:0] alu_src_b_2, alu_op_2, pc_src_2;
  logic       pc_en_2, illegal_op_2;
  logic [14:0] w0, w2;

  always #5 clk = ~clk;

  main_control_fsm #(.MEM_LAT(0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .iord(iord_0), .mem_write(mem_write_0), .ir_write(ir_write_0), .reg_dst(reg_dst_0),
    .mem_to_reg(mem_to_reg_0), .reg_write(reg_write_0), .alu_src_a(alu_src_a_0),
    .alu_src_b(alu_src_b_0), .alu_op(alu_op_0), .pc_src(pc_src_0), .pc_en(pc_en_0),
    .illegal_op(illegal_op_0)
  );

  main_control_fsm #(.MEM_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .iord(iord_2), .mem_write(mem_write_2), .ir_write(ir_write_2), .reg_dst(reg_dst_2),
    .mem_to_reg(mem_to_reg_2), .reg_write(reg_write_2), .alu_src_a(alu_src_a_2),
    .alu_src_b(alu_src_b_2), .alu_op(alu_op_2), .pc_src(pc_src_2), .pc_en(pc_en_2),
    .illegal_op(illegal_op_2)
  );

  assign w0 = {iord_0, mem_write_0, ir_write_0, reg_dst_0, mem_to_reg_0, reg_write_0,
               alu_src_a_0, alu_src_b_0, alu_op_0, pc_src_0, pc_en_0, illegal_op_0};
  assign w2 = {iord_2, mem_write_2, ir_write_2, reg_dst_2, mem_to_reg_2, reg_write_2,
               alu_src_a_2, alu_src_b_2, alu_op_2, pc_src_2, pc_en_2, illegal_op_2};

  logic [14:0] expq[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Pop one expected word per cycle, sampled 1ns after the falling edge.
  task automatic drain(input int sel, input string name);
    int i;
    logic [14:0] e;
    i = 0;
    while (expq.size() > 0) begin
      #1;
      e = expq.pop_front();
      chk($sformatf("%s[%0d]", name, i), (sel == 0) ? w0 : w2, e);
      i++;
      @(negedge clk);
    end
  endtask

  task automatic rst_start(input logic [5:0] o, input logic z);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    op    = o;
    zero  = z;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    op    = 6'b0;
    zero  = 1'b0;

    rst_start(6'b100011, 1'b0);
    expq = '{W_FETCH_L, W_DECODE, W_MEMADR, W_MEMRD, W_MEMWB, W_FETCH_L};
    drain(0, "lw_lat0");

    rst_start(6'b000000, 1'b0);
    expq = '{W_FETCH_L, W_DECODE, W_RTYPEEX, W_RTYPEWB, W_FETCH_L};
    drain(0, "rtype");

    rst_start(6'b000100, 1'b1);
    expq = '{W_FETCH_L, W_DECODE, W_BEQ_Z1, W_FETCH_L};
    drain(0, "beq_taken");
    zero = 1'b0;
    expq = '{W_DECODE, W_BEQ_Z0, W_FETCH_L};
    drain(0, "beq_not_taken");

    rst_start(6'b000010, 1'b0);
    expq = '{W_FETCH_L, W_DECODE, W_JEX, W_FETCH_L};
    drain(0, "jump");

    rst_start(6'b101011, 1'b0);
    expq = '{W_FETCH_W, W_FETCH_W, W_FETCH_L, W_DECODE, W_MEMADR,
             W_MEMWR_W, W_MEMWR_W, W_MEMWR_L, W_FETCH_W};
    drain(2, "sw_lat2");

    rst_start(6'b100011, 1'b0);
    expq = '{W_FETCH_W, W_FETCH_W, W_FETCH_L, W_DECODE, W_MEMADR,
             W_MEMRD, W_MEMRD, W_MEMRD, W_MEMWB, W_FETCH_W};
    drain(2, "lw_lat2");

    rst_start(6'b111111, 1'b0);
    expq = '{W_FETCH_L, W_DEC_ILL, W_FETCH_L, W_DEC_ILL, W_FETCH_L};
    drain(0, "illegal");

    rst_start(6'b001000, 1'b0);
`ifdef CTRL_ADDI_EN
    expq = '{W_FETCH_L, W_DECODE, W_ADDIEX, W_ADDIWB, W_FETCH_L};
`else
    expq = '{W_FETCH_L, W_DEC_ILL, W_FETCH_L, W_DEC_ILL};
`endif
    drain(0, "addi");

    // Reset one cycle before the MEMWR strobe: the strobe must never appear.
    rst_start(6'b101011, 1'b0);
    expq = '{W_FETCH_W, W_FETCH_W, W_FETCH_L, W_DECODE, W_MEMADR, W_MEMWR_W};
    drain(2, "sw_abort_pre");
    reset = 1'b1;
    expq = '{W_MEMWR_W, W_FETCH_W, W_FETCH_W};
    drain(2, "sw_abort_lat2");
    reset = 1'b0;

    rst_start(6'b101011, 1'b0);
    expq = '{W_FETCH_L, W_DECODE, W_MEMADR};
    drain(0, "sw_abort0_pre");
    reset = 1'b1;
    expq = '{W_MEMWR_L, W_FETCH_L};
    drain(0, "sw_abort_lat0");
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
